wb_lane_scheduler: RTL

WB_LANE_SCHEDULER -- requirements
Module: wb_lane_scheduler

---
 rtl/wb_pkg.sv | 20 ++
 rtl/lane_priority_enc.sv | 22 ++
 rtl/wb_lane_scheduler.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// ---------------------------------------------------------------------------
// wb_pkg
// Shared definitions for the lane write-back scheduler.
//   LANES  : number of SIMD lanes / register files written back
//   DATA_W : width of one lane result
//   REG_W  : width of the destination register index
//   wb_state_e : scheduler FSM states (IDLE accepts, WRITE drains lanes)
// ---------------------------------------------------------------------------
package wb_pkg;

    localparam int LANES  = 4;
    localparam int DATA_W = 16;
    localparam int REG_W  = 4;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } wb_state_e;

endpackage

// File: rtl/lane_priority_enc.sv
// ---------------------------------------------------------------------------
// lane_priority_enc
// Combinational lowest-set-bit finder over the pending-lane vector.
//   req    [LANES-1:0] in  : lanes still waiting to be written
//   onehot [LANES-1:0] out : one-hot select of the lowest set bit of req
//   valid              out : at least one bit of req is set
// ---------------------------------------------------------------------------
module lane_priority_enc
    import wb_pkg::*;
(
    input  logic [LANES-1:0] req,
    output logic [LANES-1:0] onehot,
    output logic             valid
);

    // Two's-complement trick: req & -req isolates the lowest set bit.
    always_comb begin
        onehot = req & (~req + LANES'(1));
        valid  = |req;
    end

endmodule

// File: rtl/wb_lane_scheduler.sv
// ---------------------------------------------------------------------------
// wb_lane_scheduler
// Serialises one multi-lane write-back request onto a shared write bus, one
// lane per cycle, lowest enabled lane first.
//   clk, rst        : clock, synchronous active-high reset
//   flush           : drop pending writes, refuse the current request
//   reqValid/Ready  : request handshake (ready whenever the FSM is IDLE)
//   reqRd           : destination register, shared by all lanes
//   reqMask         : lane enables, bit k = write lane k
//   reqData0..3     : per-lane results
//   wbWe            : one-hot lane write enable (registered)
//   wbRd, wbData    : write address / data, zero when no write (registered)
//   busy            : FSM in WRITE, used as pipeline stall
//   done            : one-cycle pulse when a request has fully retired
// ---------------------------------------------------------------------------
module wb_lane_scheduler #(
    parameter int LANES  = wb_pkg::LANES,
    parameter int DATA_W = wb_pkg::DATA_W,
    parameter int REG_W  = wb_pkg::REG_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              reqValid,
    output logic              reqReady,
    input  logic [REG_W-1:0]  reqRd,
    input  logic [LANES-1:0]  reqMask,
    input  logic [DATA_W-1:0] reqData0,
    input  logic [DATA_W-1:0] reqData1,
    input  logic [DATA_W-1:0] reqData2,
    input  logic [DATA_W-1:0] reqData3,
    output logic [LANES-1:0]  wbWe,
    output logic [REG_W-1:0]  wbRd,
    output logic [DATA_W-1:0] wbData,
    output logic              busy,
    output logic              done
);

    import wb_pkg::*;

    wb_state_e                    state_q,   state_d;
    logic [LANES-1:0]             pending_q, pending_d;
    logic [REG_W-1:0]             rd_q,      rd_d;
    logic [LANES-1:0][DATA_W-1:0] data_q,    data_d;
    logic [LANES-1:0]             we_q,      we_d;
    logic [REG_W-1:0]             wb_rd_q,   wb_rd_d;
    logic [DATA_W-1:0]            wb_data_q, wb_data_d;
    logic                         done_q,    done_d;

    logic [LANES-1:0]  lane_sel;
    logic              lane_valid;
    logic [LANES-1:0]  pending_left;
    logic              last_write;
    logic [DATA_W-1:0] lane_data;
    logic              accept;

    lane_priority_enc u_lane_priority_enc (
        .req    (pending_q),
        .onehot (lane_sel),
        .valid  (lane_valid)
    );

    assign reqReady = (state_q == IDLE);
    assign busy     = (state_q == WRITE);
    // rst is folded in so nothing is captured while reset is held.
    assign accept   = reqValid && reqReady && !flush && !rst;

    assign pending_left = pending_q & ~lane_sel;
    assign last_write   = (pending_left == '0);

    assign wbWe   = we_q;
    assign wbRd   = wb_rd_q;
    assign wbData = wb_data_q;
    assign done   = done_q;

    // AND-OR mux of the held lane data under the one-hot lane select.
    always_comb begin
        lane_data = '0;
        for (int k = 0; k < LANES; k++) begin
            lane_data = lane_data | (data_q[k] & {DATA_W{lane_sel[k]}});
        end
    end

    // Next-state logic: FSM state and the pending-lane vector.
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        if (flush) begin
            state_d   = IDLE;
            pending_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    // A zero mask retires straight from IDLE.
                    if (accept && (reqMask != '0)) begin
                        state_d   = WRITE;
                        pending_d = reqMask;
                    end else begin
                        state_d   = IDLE;
                        pending_d = pending_q;
                    end
                end
                WRITE: begin
                    // Leaving on the last write lets a new request be taken
                    // in the same cycle the last write is on the bus.
                    pending_d = pending_left;
                    if (last_write) begin
                        state_d = IDLE;
                    end else begin
                        state_d = WRITE;
                    end
                end
                default: begin
                    state_d   = IDLE;
                    pending_d = '0;
                end
            endcase
        end
    end

    // Output and holding-register logic: capture on accept, drive one lane per cycle.
    always_comb begin
        rd_d      = rd_q;
        data_d    = data_q;
        we_d      = '0;
        wb_rd_d   = '0;
        wb_data_d = '0;
        done_d    = 1'b0;
        if (accept) begin
            rd_d   = reqRd;
            data_d = {reqData3, reqData2, reqData1, reqData0};
        end else begin
            rd_d   = rd_q;
            data_d = data_q;
        end
        if (flush) begin
            done_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_d = accept && (reqMask == '0);
                end
                WRITE: begin
                    if (lane_valid) begin
                        we_d      = lane_sel;
                        wb_rd_d   = rd_q;
                        wb_data_d = lane_data;
                        done_d    = last_write;
                    end else begin
                        done_d    = 1'b0;
                    end
                end
                default: begin
                    done_d = 1'b0;
                end
            endcase
        end
    end

    // State register: every flop of the block, synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            pending_q <= '0;
            rd_q      <= '0;
            data_q    <= '0;
            we_q      <= '0;
            wb_rd_q   <= '0;
            wb_data_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            rd_q      <= rd_d;
            data_q    <= data_d;
            we_q      <= we_d;
            wb_rd_q   <= wb_rd_d;
            wb_data_q <= wb_data_d;
            done_q    <= done_d;
        end
    end

endmodule
